// File: rtl/flp_pack_arb.sv
// flp_pack_arb: shares one flp_pack between NREQ unpacked-result producers.
// A round-robin arbiter grants at most one requester per cycle. The granted
// fields are packed combinationally and written into a registered 2-entry
// FIFO. The FIFO head drives a valid/ready consumer together with the index
// of the source requester.
// Optional feature: define FLP_PACK_ARB_PERF_EN to add o_stall_cnt. This is a
// saturating 16-bit count of cycles in which a request is pending but not
// granted.
// flp_pack packing rules: nan > inf > zero > normal. NaN packs as a positive
// canonical quiet NaN. A clear hidden bit packs as a subnormal with a zero
// biased exponent field.

module flp_pack #(
  parameter int EWIDTH = 8,
  parameter int SWIDTH = 23
) (
  input  logic              sn,
  input  logic [EWIDTH-1:0] ex,
  input  logic [SWIDTH:0]   sg,
  input  logic              zero,
  input  logic              nan,
  input  logic              inf,
  output logic [EWIDTH+SWIDTH:0] fpd
);

  // Flag-prioritised field packing; the hidden bit is dropped from storage
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    fpd = {sn, ex, sg[SWIDTH-1:0]};
    if (nan)
      fpd = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(SWIDTH-1){1'b0}}};
    else if (inf)
      fpd = {sn, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
    else if (zero)
      fpd = {sn, {(EWIDTH+SWIDTH){1'b0}}};
    else if (!sg[SWIDTH])
      fpd = {sn, {EWIDTH{1'b0}}, sg[SWIDTH-1:0]};
  end

endmodule

module flp_pack_arb #(
  parameter  int EWIDTH = 8,
  parameter  int SWIDTH = 23,
  parameter  int NREQ   = 4,
  localparam int SRCW   = $clog2(NREQ),
  localparam int FW     = EWIDTH + SWIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          i_req_vld,
  output logic [NREQ-1:0]          o_req_rdy,
  input  logic [NREQ-1:0]          i_req_sn,
  input  logic [NREQ*EWIDTH-1:0]   i_req_ex,
  input  logic [NREQ*(SWIDTH+1)-1:0] i_req_sg,
  input  logic [NREQ-1:0]          i_req_zero,
  input  logic [NREQ-1:0]          i_req_nan,
  input  logic [NREQ-1:0]          i_req_inf,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [FW-1:0]            o_fpd,
  output logic [SRCW-1:0]          o_src
`ifdef FLP_PACK_ARB_PERF_EN
  ,
  output logic [15:0]              o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SRCW-1:0] ptr;
  logic [SRCW-1:0] gnt_idx;
  logic [SRCW-1:0] cand;
  logic            found;
  logic            space;
  logic            push;
  logic            pop;

  logic              sel_sn;
  logic [EWIDTH-1:0] sel_ex;
  logic [SWIDTH:0]   sel_sg;
  logic              sel_zero;
  logic              sel_nan;
  logic              sel_inf;
  logic [FW-1:0]     packed_word;

  // Second FIFO entry; the head lives directly in o_fpd/o_src
  logic [FW-1:0]   buf1_fpd;
  logic [SRCW-1:0] buf1_src;

  // Round-robin search: first valid requester starting at ptr, wrapping
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = SRCW'((int'(ptr) + i) % NREQ);
      if (!found && i_req_vld[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Space comes from registered state only, so i_rdy never reaches o_req_rdy
  assign space     = !rst && (state != TWO);
  assign push      = found && space;
  assign o_req_rdy = push ? (NREQ'(1) << gnt_idx) : '0;
  assign o_vld     = (state != EMPTY);
  assign pop       = o_vld && i_rdy;

  // Route the granted requester's fields into the shared packer
  assign sel_sn   = i_req_sn[gnt_idx];
  assign sel_ex   = i_req_ex[gnt_idx*EWIDTH +: EWIDTH];
  assign sel_sg   = i_req_sg[gnt_idx*(SWIDTH+1) +: (SWIDTH+1)];
  assign sel_zero = i_req_zero[gnt_idx];
  assign sel_nan  = i_req_nan[gnt_idx];
  assign sel_inf  = i_req_inf[gnt_idx];

  flp_pack #(
    .EWIDTH(EWIDTH),
    .SWIDTH(SWIDTH)
  ) u_pack (
    .sn  (sel_sn),
    .ex  (sel_ex),
    .sg  (sel_sg),
    .zero(sel_zero),
    .nan (sel_nan),
    .inf (sel_inf),
    .fpd (packed_word)
  );

  // Buffer occupancy register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Occupancy transitions from push/pop
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (pop && !push) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Round-robin pointer: one past the last granted requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (push)
      ptr <= (gnt_idx == SRCW'(NREQ-1)) ? '0 : gnt_idx + SRCW'(1);
  end

  // Two-entry FIFO storage: write the tail, shift up on pop
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the storage is tiny and its head is a port, so it is reset to give o_fpd/o_src defined values.
    if (rst) begin
      o_fpd    <= '0;
      o_src    <= '0;
      buf1_fpd <= '0;
      buf1_src <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            o_fpd <= packed_word;
            o_src <= gnt_idx;
          end
        end
        ONE: begin
          if (push && pop) begin
            o_fpd <= packed_word;
            o_src <= gnt_idx;
          end else if (push) begin
            buf1_fpd <= packed_word;
            buf1_src <= gnt_idx;
          end
        end
        TWO: begin
          if (pop) begin
            o_fpd <= buf1_fpd;
            o_src <= buf1_src;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FLP_PACK_ARB_PERF_EN
  // Saturating count of cycles with a pending request but no grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_stall_cnt <= '0;
    else if (|i_req_vld && !push && o_stall_cnt != 16'hFFFF)
      o_stall_cnt <= o_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_flp_pack_arb.sv
// Self-checking bench for flp_pack_arb (EWIDTH=8, SWIDTH=23, NREQ=4).
// A reference model computes grants and packed words; expected words go into a
// scoreboard queue that a separate monitor drains on each output transfer.

module tb_flp_pack_arb;

  localparam int EWIDTH = 8;
  localparam int SWIDTH = 23;
  localparam int NREQ   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  i_req_vld = '0;
  logic [3:0]  o_req_rdy;
  logic [3:0]  i_req_sn = '0;
  logic [31:0] i_req_ex = '0;
  logic [95:0] i_req_sg = '0;
  logic [3:0]  i_req_zero = '0;
  logic [3:0]  i_req_nan = '0;
  logic [3:0]  i_req_inf = '0;
  logic        o_vld;
  logic        i_rdy = 1'b0;
  logic [31:0] o_fpd;
  logic [1:0]  o_src;
`ifdef FLP_PACK_ARB_PERF_EN
  logic [15:0] o_stall_cnt;
`endif

  flp_pack_arb #(
    .EWIDTH(EWIDTH),
    .SWIDTH(SWIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req_vld  (i_req_vld),
    .o_req_rdy  (o_req_rdy),
    .i_req_sn   (i_req_sn),
    .i_req_ex   (i_req_ex),
    .i_req_sg   (i_req_sg),
    .i_req_zero (i_req_zero),
    .i_req_nan  (i_req_nan),
    .i_req_inf  (i_req_inf),
    .o_vld      (o_vld),
    .i_rdy      (i_rdy),
    .o_fpd      (o_fpd),
    .o_src      (o_src)
`ifdef FLP_PACK_ARB_PERF_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fpd;
    int          src;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   ptr_m      = 0;
  int   stall_m    = 0;
  bit   granted[4];
  bit   rnd_mode   = 1'b0;
  bit   hold       = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference packing straight from the field rules
  function automatic logic [31:0] ref_pack(input int k);
    logic        sn = i_req_sn[k];
    logic [7:0]  ex = i_req_ex[k*8 +: 8];
    logic [23:0] sg = i_req_sg[k*24 +: 24];
    if (i_req_nan[k])  return 32'h7FC00000;
    if (i_req_inf[k])  return {sn, 8'hFF, 23'h0};
    if (i_req_zero[k]) return {sn, 31'h0};
    if (!sg[23])       return {sn, 8'h00, sg[22:0]};
    return {sn, ex, sg[22:0]};
  endfunction

  task automatic set_req(input int k, input bit sn, input logic [7:0] ex, input logic [23:0] sg,
                         input bit z, input bit n, input bit f);
    i_req_vld[k]          = 1'b1;
    i_req_sn[k]           = sn;
    i_req_ex[k*8 +: 8]    = ex;
    i_req_sg[k*24 +: 24]  = sg;
    i_req_zero[k]         = z;
    i_req_nan[k]          = n;
    i_req_inf[k]          = f;
  endtask

  task automatic clr_req(input int k);
    i_req_vld[k] = 1'b0;
  endtask

  task automatic rand_req(input int k);
    int r = $urandom_range(0, 15);
    if ($urandom_range(0, 9) < 6)
      set_req(k, 1'($urandom), 8'($urandom), {($urandom_range(0, 7) != 0), 23'($urandom)},
              r == 2, r == 0, r == 1);
    else
      clr_req(k);
  endtask

  // Model for one cycle, evaluated mid-cycle before the edge
  task automatic model_cycle();
    int         g = -1;
    logic [3:0] exp_rdy = '0;
    if (!rst && sbq.size() < 2) begin
      for (int i = 0; i < 4; i++) begin
        int k = (ptr_m + i) % 4;
        if (g < 0 && i_req_vld[k]) g = k;
      end
    end
    if (g >= 0) exp_rdy = 4'(1 << g);
    check("req_rdy", o_req_rdy, exp_rdy);
`ifdef FLP_PACK_ARB_PERF_EN
    check("stall_cnt", o_stall_cnt, stall_m);
    if (!rst && |i_req_vld && g < 0 && stall_m < 65535) stall_m++;
`endif
    if (g >= 0) begin
      sbq.push_back('{ref_pack(g), g, cyc});
      ptr_m      = (g + 1) % 4;
      granted[g] = 1'b1;
    end
  endtask

  // One clock: model at negedge, then update stimulus 1 time unit after posedge
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (granted[k]) begin
        granted[k] = 1'b0;
        if (rnd_mode)   rand_req(k);
        else if (!hold) clr_req(k);
      end else if (rnd_mode && !i_req_vld[k]) begin
        rand_req(k);
      end
    end
    if (rnd_mode) i_rdy = ($urandom_range(0, 3) != 0);
  endtask

  // Monitor: compare the FIFO head against the scoreboard on every output
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) continue;
      if (sbq.size() == 0) begin
        check("idle_vld", o_vld, 1'b0);
      end else if (sbq[0].cyc == cyc) begin
        check("latency_vld", o_vld, 1'b0);
      end else begin
        check("vld", o_vld, 1'b1);
        if (o_vld) begin
          check("fpd", o_fpd, sbq[0].fpd);
          check("src", o_src, 64'(sbq[0].src));
          if (i_rdy) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset state, with a request already pending to show o_req_rdy is held low
    set_req(0, 1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 1'b0);
    i_rdy = 1'b1;
    #2;
    check("rst_vld", o_vld, 1'b0);
    check("rst_fpd", o_fpd, 32'h0);
    check("rst_src", o_src, 2'd0);
    check("rst_req_rdy", o_req_rdy, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request: 1.0
    step();
    check("single_vld", o_vld, 1'b1);
    check("single_fpd", o_fpd, 32'h3F800000);
    check("single_src", o_src, 2'd0);
    step();

    // Round-robin with all four held valid
    hold = 1'b1;
    for (int k = 0; k < 4; k++)
      set_req(k, 1'($urandom), 8'($urandom), {1'b1, 23'($urandom)}, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    hold = 1'b0;
    for (int k = 0; k < 4; k++) clr_req(k);
    repeat (3) step();

    // Backpressure: only two fit, third waits until the consumer drains
    i_rdy = 1'b0;
    for (int k = 0; k < 3; k++)
      set_req(k, 1'($urandom), 8'($urandom), {1'b1, 23'($urandom)}, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check("bp_rdy_blocked", o_req_rdy, 4'h0);
    i_rdy = 1'b1;
    repeat (4) step();

    // Flags
    set_req(2, 1'b1, 8'h55, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
    step();
    check("zero_fpd", o_fpd, 32'h80000000);
    check("zero_src", o_src, 2'd2);
    set_req(1, 1'b0, 8'h12, 24'h923456, 1'b0, 1'b0, 1'b1);
    step();
    check("inf_fpd", o_fpd, 32'h7F800000);
    check("inf_src", o_src, 2'd1);
    set_req(3, 1'b1, 8'h80, 24'hC00000, 1'b1, 1'b1, 1'b1);
    repeat (3) step();

    // Reset mid-operation with the buffer full
    i_rdy = 1'b0;
    set_req(2, 1'b0, 8'h81, 24'hA00000, 1'b0, 1'b0, 1'b0);
    set_req(3, 1'b1, 8'h70, 24'hF00000, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_vld", o_vld, 1'b0);
    check("midrst_fpd", o_fpd, 32'h0);
    sbq.delete();
    ptr_m   = 0;
    stall_m = 0;
    for (int k = 0; k < 4; k++)
      set_req(k, 1'($urandom), 8'($urandom), {1'b1, 23'($urandom)}, 1'b0, 1'b0, 1'b0);
    step();
    rst   = 1'b0;
    i_rdy = 1'b1;
    step();
    check("post_rst_src", o_src, 2'd0);
    for (int k = 0; k < 4; k++) clr_req(k);
    repeat (3) step();

`ifdef FLP_PACK_ARB_PERF_EN
    // Stall counter: two accepted, eight stalled cycles
    #2;
    rst = 1'b1;
    sbq.delete();
    ptr_m   = 0;
    stall_m = 0;
    step();
    rst   = 1'b0;
    i_rdy = 1'b0;
    hold  = 1'b1;
    set_req(3, 1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 1'b0);
    repeat (10) step();
    check("perf_stall_cnt", o_stall_cnt, 16'd8);
    hold  = 1'b0;
    clr_req(3);
    i_rdy = 1'b1;
    repeat (3) step();
`endif

    // Randomized traffic with random backpressure
    rnd_mode = 1'b1;
    repeat (3000) step();
    rnd_mode = 1'b0;
    for (int k = 0; k < 4; k++) clr_req(k);
    i_rdy = 1'b1;
    repeat (6) step();
    check("drain_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
